ca_rand_checker: RTL
====================

Name: ca_rand_checker

Overview:
- Memory-mapped PRBS checker for the Rule-30 cellular-automaton random number peripheral.
- Runs a local copy of the 12-cell Rule-30 automaton and compares each received 8-bit sample against the expected byte.
- Tracks lock state and counts mismatches. The CPU seeds, reads and clears it with COPYTO/COPYFROM on its own address window.
- Sits beside the generator on the I/O bus. Its sample input is driven from the generator's output.

Parameters:
- SEED, 12'hDA9, state loaded on reset; matches the generator's reset seed.
- RULE, 8'd30, automaton rule; cell_next = RULE[{left,self,right}].
- WIDTH, 12, automaton cell count; ring wrap at both ends.
- ADDR_BASE, 8'd20, base of a 4-address register window.
- LOCK_COUNT, 4, consecutive matches needed to go SYNC -> LOCKED.
- LOSS_COUNT, 3, consecutive mismatches needed to go LOCKED -> LOST.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- addr  in  8  bus address
- write_en  in  1  bus write strobe
- din  in  8  bus write data
- dout  out  8  bus read data; combinational mux on addr
- sample_valid  in  1  sample_data is valid this cycle
- sample_data  in  8  observed generator byte
- locked  out  1  high in LOCKED state

Behaviour:
- Register map (addr - ADDR_BASE):
  - +0 write: seed.
  - +1 read: status {state[1:0], err_sat, 5'b0}.
  - +2 read: errcnt; write of any value clears it.
  - +3 read: expected byte.
  - Out-of-window addr: dout = 8'h00.
- Local state q[WIDTH-1:0]:
  - Next state nxt[i] = RULE[{q[i-1 mod W], q[i], q[i+1 mod W]}].
  - Expected byte exp = nxt[9:2].
- Reset (rst=0, asynchronous):
  - q = SEED, state = SYNC, match_cnt = 0, miss_cnt = 0, errcnt = 0, err_sat = 0.
  - locked = 0, dout = 0 unless addr is in the window.
- Seed write (write_en, offset +0):
  - q <= {4'b0000, din}; state <= SYNC; match_cnt, miss_cnt, errcnt, err_sat cleared.
  - A seed write takes priority over a sample in the same cycle; that sample is dropped.
- Sample (sample_valid, no seed write):
  - Compare sample_data with exp; q <= nxt. One step per sample, latency 0: the result is visible in status the next cycle.
  - Match: match_cnt++ (saturating at LOCK_COUNT); miss_cnt <= 0.
  - Mismatch: errcnt++, saturating at 8'hFF, with err_sat set at saturation; match_cnt <= 0; miss_cnt++ (saturating at LOSS_COUNT).
- No sample_valid: q holds. The feeder must present every generator output consecutively.
- FSM, state encoding SYNC=2'b01, LOCKED=2'b10, LOST=2'b11:
  - SYNC -> LOCKED when match_cnt reaches LOCK_COUNT.
  - LOCKED -> LOST when miss_cnt reaches LOSS_COUNT.
  - LOST exits only via reset or seed write. Compares and errcnt keep running in LOST.
- Errcnt clear in the same cycle as a mismatch: the clear wins, and errcnt = 0.
- locked is registered and equals (state == LOCKED).

Optional Feature:
- Macro: CA_CHK_IRQ_EN.
- When defined:
  - Adds output irq (1 bit).
  - irq pulses high for exactly one cycle on the LOCKED -> LOST transition.
  - irq resets to 0.
- When undefined: no irq port and no related logic. All other behaviour is identical.

Test Plan:
- Reset, then 6 samples from the golden model starting at SEED 12'hDA9 -> locked=1 after the 4th sample, errcnt=0, status[7:6]=2'b10.
- Write 8'h00 to +0, then feed 8'h00 x4 -> exp stays 8'h00, LOCKED after 4 samples. Next feed 8'hFF, 8'h00 -> errcnt=1, still LOCKED.
- In LOCKED, feed 3 consecutive wrong bytes -> status state=2'b11, locked=0. With CA_CHK_IRQ_EN: irq high exactly one cycle.
- 300 consecutive mismatches after a seed write -> errcnt=8'hFF, err_sat=1. Write +2 -> errcnt=0, err_sat=0.
- Seed write of 8'h01 in the same cycle as sample_valid -> sample ignored, q=12'h001, read +3 = 8'h00, state SYNC.
- Assert rst mid-stream while LOCKED with errcnt=5 -> immediately state SYNC, errcnt=0, locked=0, q=SEED.

Source files
------------

// File: rtl/ca_rand_checker.sv
// ca_rand_checker: Rule-30 cellular-automaton PRBS checker with a CPU register window.
// Optional macro CA_CHK_IRQ_EN adds a one-cycle irq output on loss of lock.
module ca_rand_checker #(
   parameter int               WIDTH      = 12,
   parameter logic [WIDTH-1:0] SEED       = 12'hDA9,
   parameter logic [7:0]       RULE       = 8'd30,
   parameter logic [7:0]       ADDR_BASE  = 8'd20,
   parameter int               LOCK_COUNT = 4,
   parameter int               LOSS_COUNT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] addr,
   input  logic       write_en,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       sample_valid,
   input  logic [7:0] sample_data,
`ifdef CA_CHK_IRQ_EN
   output logic       irq,
`endif
   output logic       locked
);

   localparam logic [1:0] S_SYNC   = 2'b01;
   localparam logic [1:0] S_LOCKED = 2'b10;
   localparam logic [1:0] S_LOST   = 2'b11;

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int XW = $clog2(LOSS_COUNT + 1);
   localparam logic [MW-1:0] M_MAX = MW'(LOCK_COUNT);
   localparam logic [XW-1:0] X_MAX = XW'(LOSS_COUNT);

   logic [WIDTH-1:0] q, q_n, nxt;
   logic [1:0]       state, st_n;
   logic [MW-1:0]    match_cnt, mc_n;
   logic [XW-1:0]    miss_cnt, xc_n;
   logic [7:0]       errcnt, ec_n;
   logic             err_sat, es_n;
   logic [7:0]       off, exp_byte;
   logic             in_win, seed_wr, clr_wr, step, hit;

   assign off      = addr - ADDR_BASE;
   assign in_win   = off < 8'd4;
   assign seed_wr  = write_en && in_win && (off[1:0] == 2'd0);
   assign clr_wr   = write_en && in_win && (off[1:0] == 2'd2);
   assign step     = sample_valid && !seed_wr;
   assign exp_byte = nxt[9:2];
   assign hit      = sample_data == exp_byte;

   // One automaton step on a ring: each cell looks up the rule by its neighbourhood.
   always_comb begin
      nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nxt[i] = RULE[{q[(i + WIDTH - 1) % WIDTH], q[i], q[(i + 1) % WIDTH]}];
      end
   end

   // Next-state for automaton, counters and lock FSM; a seed write overrides a sample.
   always_comb begin
      q_n  = q;
      st_n = state;
      mc_n = match_cnt;
      xc_n = miss_cnt;
      ec_n = errcnt;
      es_n = err_sat;
      if (seed_wr) begin
         q_n  = WIDTH'(din);
         st_n = S_SYNC;
         mc_n = '0;
         xc_n = '0;
         ec_n = 8'h00;
         es_n = 1'b0;
      end else begin
         if (step) begin
            q_n = nxt;
            if (hit) begin
               mc_n = (match_cnt == M_MAX) ? match_cnt : match_cnt + MW'(1);
               xc_n = '0;
            end else begin
               mc_n = '0;
               xc_n = (miss_cnt == X_MAX) ? miss_cnt : miss_cnt + XW'(1);
               if (errcnt != 8'hFF) ec_n = errcnt + 8'd1;
               if (ec_n == 8'hFF) es_n = 1'b1;
            end
            unique case (1'b1)
               (state == S_SYNC):   if (mc_n == M_MAX) st_n = S_LOCKED;
               (state == S_LOCKED): if (xc_n == X_MAX) st_n = S_LOST;
               default: ;
            endcase
         end
         if (clr_wr) begin
            ec_n = 8'h00;
            es_n = 1'b0;
         end
      end
   end

   // State registers, including the registered lock indicator.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q         <= SEED;
         state     <= S_SYNC;
         match_cnt <= '0;
         miss_cnt  <= '0;
         errcnt    <= 8'h00;
         err_sat   <= 1'b0;
         locked    <= 1'b0;
      end else begin
         q         <= q_n;
         state     <= st_n;
         match_cnt <= mc_n;
         miss_cnt  <= xc_n;
         errcnt    <= ec_n;
         err_sat   <= es_n;
         locked    <= st_n == S_LOCKED;
      end
   end

`ifdef CA_CHK_IRQ_EN
   // Single-cycle pulse when lock is lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) irq <= 1'b0;
      else      irq <= (state == S_LOCKED) && (st_n == S_LOST);
   end
`endif

   // Read mux over the register window; zero outside it.
   always_comb begin
      dout = 8'h00;
      if (in_win) begin
         unique case (off[1:0])
            2'd1:    dout = {state, err_sat, 5'b00000};
            2'd2:    dout = errcnt;
            2'd3:    dout = exp_byte;
            default: dout = 8'h00;
         endcase
      end
   end

endmodule
